// File: rtl/ddr3_dqsw_pkg.sv
// Shared types and constants for the DDR3 DQS write-leveling training controller.
package ddr3_dqsw_pkg;

  localparam int TAP_W = 8;
  localparam logic [1:0] DQS_PATTERN = 2'b01;
  localparam logic [1:0] OE_ON = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_DONE,
    ST_ERR,
    ST_EYE_CLR,
    ST_EYE_WAIT,
    ST_EYE_ADJ
  } state_t;

endpackage

// File: rtl/ddr3_dqsw_probe_timer.sv
// Down-counter shared by the DQS burst, settle and eye-wait phases; tc marks the last cycle of a phase.
module ddr3_dqsw_probe_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] len,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ddr3_dqsw_training_ctrl.sv
// DQS write-leveling sweep for one DDR3 PHY lane: probe, sample feedback, step taps until a filtered 0->1 edge.
// Optional post-lock eye-monitor refinement is built when DQSW_EYE_CHECK_EN is defined.
module ddr3_dqsw_training_ctrl
  import ddr3_dqsw_pkg::*;
#(
  parameter int TAP_MAX       = 128,
  parameter int SETTLE_CYCLES = 16,
  parameter int BURST_LEN     = 4,
  parameter int FILTER        = 3
) (
  input  logic             fab_clk,
  input  logic             arst_n,
  input  logic             train_start,
  output logic             train_done,
  output logic             train_err,
  output logic [TAP_W-1:0] tap_count,
  output logic [1:0]       tx_data_0,
  output logic [1:0]       oe_data_0,
  output logic             odt_en_0,
  input  logic [1:0]       rx_data_0,
  output logic             delay_line_move_0,
  output logic             delay_line_direction_0,
  output logic             delay_line_load_0,
  input  logic             delay_line_out_of_range_0,
  output logic             eye_monitor_clear_flags_0,
  input  logic             eye_monitor_early_0,
  input  logic             eye_monitor_late_0
);

  localparam int TMR_W = 16;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_MAX - 1);

  state_t           state;
  logic             seen_zero;
  logic [7:0]       ones_cnt;
  logic             fb;
  logic             lock;
  logic             tmr_load;
  logic             tmr_tc;
  logic [TMR_W-1:0] tmr_len;
  logic             unused_in;

  // Timer is reloaded on the cycle before each timed phase begins.
  assign tmr_load = (state == ST_LOAD) || (state == ST_STEP) || (state == ST_EYE_CLR) ||
                    ((state == ST_PULSE) && tmr_tc);
  assign tmr_len  = ((state == ST_PULSE) || (state == ST_EYE_CLR)) ? TMR_W'(SETTLE_CYCLES)
                                                                  : TMR_W'(BURST_LEN);

  ddr3_dqsw_probe_timer #(.W(TMR_W)) u_timer (
    .clk   (fab_clk),
    .rst_n (arst_n),
    .load  (tmr_load),
    .len   (tmr_len),
    .tc    (tmr_tc)
  );

  assign fb   = rx_data_0[0];
  assign lock = fb && seen_zero && (ones_cnt == 8'(FILTER - 1));

`ifdef DQSW_EYE_CHECK_EN
  logic clr_q;
  logic adj_once;
  assign eye_monitor_clear_flags_0 = clr_q;
  assign unused_in = rx_data_0[1];
`else
  assign eye_monitor_clear_flags_0 = 1'b0;
  assign unused_in = ^{rx_data_0[1], eye_monitor_early_0, eye_monitor_late_0};
`endif

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state                  <= ST_IDLE;
      seen_zero              <= 1'b0;
      ones_cnt               <= '0;
      train_done             <= 1'b0;
      train_err              <= 1'b0;
      tap_count              <= '0;
      tx_data_0              <= '0;
      oe_data_0              <= '0;
      odt_en_0               <= 1'b0;
      delay_line_move_0      <= 1'b0;
      delay_line_direction_0 <= 1'b0;
      delay_line_load_0      <= 1'b0;
`ifdef DQSW_EYE_CHECK_EN
      clr_q                  <= 1'b0;
      adj_once               <= 1'b0;
`endif
    end else begin
      delay_line_move_0 <= 1'b0;
      delay_line_load_0 <= 1'b0;
`ifdef DQSW_EYE_CHECK_EN
      clr_q             <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (train_start) begin
            state             <= ST_LOAD;
            delay_line_load_0 <= 1'b1;
            tap_count         <= '0;
            seen_zero         <= 1'b0;
            ones_cnt          <= '0;
            odt_en_0          <= 1'b1;
            train_done        <= 1'b0;
            train_err         <= 1'b0;
`ifdef DQSW_EYE_CHECK_EN
            adj_once          <= 1'b0;
`endif
          end
        end
        default: begin
          if (delay_line_out_of_range_0) begin
            state     <= ST_ERR;
            train_err <= 1'b1;
            odt_en_0  <= 1'b0;
            tx_data_0 <= '0;
            oe_data_0 <= '0;
          end else begin
            case (state)
              ST_LOAD, ST_STEP: begin
                state     <= ST_PULSE;
                tx_data_0 <= DQS_PATTERN;
                oe_data_0 <= OE_ON;
              end
              ST_PULSE: begin
                if (tmr_tc) begin
                  state     <= ST_SETTLE;
                  tx_data_0 <= '0;
                  oe_data_0 <= '0;
                end
              end
              ST_SETTLE: begin
                if (tmr_tc) state <= ST_SAMPLE;
              end
              ST_SAMPLE: begin
                if (!fb) begin
                  seen_zero <= 1'b1;
                  ones_cnt  <= '0;
                end else if (seen_zero) begin
                  ones_cnt <= ones_cnt + 8'd1;
                end
                if (lock) begin
`ifdef DQSW_EYE_CHECK_EN
                  state <= ST_EYE_CLR;
                  clr_q <= 1'b1;
`else
                  state      <= ST_DONE;
                  train_done <= 1'b1;
                  odt_en_0   <= 1'b0;
`endif
                end else if (tap_count == TAP_LAST) begin
                  state     <= ST_ERR;
                  train_err <= 1'b1;
                  odt_en_0  <= 1'b0;
                end else begin
                  state                  <= ST_STEP;
                  delay_line_move_0      <= 1'b1;
                  delay_line_direction_0 <= 1'b1;
                  tap_count              <= tap_count + TAP_W'(1);
                end
              end
`ifdef DQSW_EYE_CHECK_EN
              ST_EYE_CLR: begin
                state     <= ST_EYE_WAIT;
                tx_data_0 <= DQS_PATTERN;
                oe_data_0 <= OE_ON;
              end
              ST_EYE_WAIT: begin
                if (tmr_tc) begin
                  state     <= ST_EYE_ADJ;
                  tx_data_0 <= '0;
                  oe_data_0 <= '0;
                end
              end
              ST_EYE_ADJ: begin
                // A conflicting or absent flag, or a tap at its limit, ends refinement without a move.
                if ((eye_monitor_early_0 && !eye_monitor_late_0 && (tap_count != TAP_LAST)) ||
                    (eye_monitor_late_0 && !eye_monitor_early_0 && (tap_count != '0))) begin
                  delay_line_move_0      <= 1'b1;
                  delay_line_direction_0 <= eye_monitor_early_0;
                  tap_count <= eye_monitor_early_0 ? tap_count + TAP_W'(1) : tap_count - TAP_W'(1);
                  if (adj_once) begin
                    state      <= ST_DONE;
                    train_done <= 1'b1;
                    odt_en_0   <= 1'b0;
                  end else begin
                    adj_once <= 1'b1;
                    state    <= ST_EYE_CLR;
                    clr_q    <= 1'b1;
                  end
                end else begin
                  state      <= ST_DONE;
                  train_done <= 1'b1;
                  odt_en_0   <= 1'b0;
                end
              end
`endif
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_dqsw_training_ctrl.sv
// Self-checking bench: tap-indexed feedback patterns, lock tap predicted from the edge-filter rule over the pattern.
module tb_ddr3_dqsw_training_ctrl;

  localparam int TAP_MAX       = 128;
  localparam int SETTLE_CYCLES = 16;
  localparam int BURST_LEN     = 4;
  localparam int FILTER        = 3;
`ifdef DQSW_EYE_CHECK_EN
  localparam int EYE_R = 1;
`else
  localparam int EYE_R = 0;
`endif

  logic       fab_clk = 1'b0;
  logic       arst_n;
  logic       train_start;
  logic       train_done;
  logic       train_err;
  logic [7:0] tap_count;
  logic [1:0] tx_data_0;
  logic [1:0] oe_data_0;
  logic       odt_en_0;
  logic [1:0] rx_data_0;
  logic       delay_line_move_0;
  logic       delay_line_direction_0;
  logic       delay_line_load_0;
  logic       delay_line_out_of_range_0;
  logic       eye_monitor_clear_flags_0;
  logic       eye_early;
  logic       eye_late;

  logic       fb_arr [TAP_MAX];
  logic       oor_en;
  logic [7:0] oor_tap;
  logic [18:0] out_vec;

  int n_assert = 0;
  int n_fail   = 0;
  int n_move = 0, n_move_dn = 0, n_load = 0, n_pulse = 0, n_wide = 0, n_badpat = 0, n_clr = 0;
  logic prev_move = 1'b0, prev_load = 1'b0;

  always #5 fab_clk = ~fab_clk;

  assign rx_data_0 = {1'b0, fb_arr[tap_count[6:0]]};
  assign delay_line_out_of_range_0 = oor_en && (tap_count == oor_tap);
  assign out_vec = {train_done, train_err, tap_count, tx_data_0, oe_data_0, odt_en_0,
                    delay_line_move_0, delay_line_direction_0, delay_line_load_0,
                    eye_monitor_clear_flags_0};

  ddr3_dqsw_training_ctrl #(
    .TAP_MAX(TAP_MAX), .SETTLE_CYCLES(SETTLE_CYCLES), .BURST_LEN(BURST_LEN), .FILTER(FILTER)
  ) dut (
    .fab_clk                   (fab_clk),
    .arst_n                    (arst_n),
    .train_start               (train_start),
    .train_done                (train_done),
    .train_err                 (train_err),
    .tap_count                 (tap_count),
    .tx_data_0                 (tx_data_0),
    .oe_data_0                 (oe_data_0),
    .odt_en_0                  (odt_en_0),
    .rx_data_0                 (rx_data_0),
    .delay_line_move_0         (delay_line_move_0),
    .delay_line_direction_0    (delay_line_direction_0),
    .delay_line_load_0         (delay_line_load_0),
    .delay_line_out_of_range_0 (delay_line_out_of_range_0),
    .eye_monitor_clear_flags_0 (eye_monitor_clear_flags_0),
    .eye_monitor_early_0       (eye_early),
    .eye_monitor_late_0        (eye_late)
  );

  // Running totals of observed IOD activity, sampled mid-cycle.
  always @(negedge fab_clk) begin
    if (delay_line_move_0) n_move <= n_move + 1;
    if (delay_line_move_0 && !delay_line_direction_0) n_move_dn <= n_move_dn + 1;
    if (delay_line_load_0) n_load <= n_load + 1;
    if (eye_monitor_clear_flags_0) n_clr <= n_clr + 1;
    if ((delay_line_move_0 && prev_move) || (delay_line_load_0 && prev_load)) n_wide <= n_wide + 1;
    if (oe_data_0 == 2'b11 && tx_data_0 == 2'b01) n_pulse <= n_pulse + 1;
    else if (oe_data_0 != 2'b00 || tx_data_0 != 2'b00) n_badpat <= n_badpat + 1;
    prev_move <= delay_line_move_0;
    prev_load <= delay_line_load_0;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int t = 0; t < TAP_MAX; t++) begin
      case (mode)
        1: fb_arr[t] = (t >= 40);
        2: fb_arr[t] = (t < 10) || (t >= 30);
        3: fb_arr[t] = (t == 20) || (t >= 25);
        4: fb_arr[t] = ($urandom_range(0, 3) != 0);
        5: fb_arr[t] = (t >= 100);
        default: fb_arr[t] = 1'b0;
      endcase
    end
  endtask

  // Lock tap = first tap ending a run of FILTER ones that has some 0 earlier in the sweep; -1 if none.
  function automatic int ref_lock();
    bit win, pre;
    for (int t = FILTER; t < TAP_MAX; t++) begin
      win = 1'b1;
      pre = 1'b0;
      for (int k = t - FILTER + 1; k <= t; k++) if (!fb_arr[k]) win = 1'b0;
      for (int k = 0; k < t - FILTER + 1; k++) if (!fb_arr[k]) pre = 1'b1;
      if (win && pre) return t;
    end
    return -1;
  endfunction

  task automatic sweep(input string tag, input int exp_tap, input bit exp_err, input int probes,
                       input int eye_rounds, input bit poke);
    int m0, md0, l0, p0, w0, b0, c0, er, cyc;
    er = exp_err ? 0 : eye_rounds;
    @(negedge fab_clk);
    #2;
    m0 = n_move; md0 = n_move_dn; l0 = n_load; p0 = n_pulse; w0 = n_wide; b0 = n_badpat; c0 = n_clr;
    train_start = 1'b1;
    @(negedge fab_clk);
    chk({tag, "_load_strobe"}, int'(delay_line_load_0), 1);
    chk({tag, "_load_tap"}, int'(tap_count), 0);
    chk({tag, "_odt_on"}, int'(odt_en_0), 1);
    train_start = 1'b0;
    if (poke) begin
      repeat (30) @(negedge fab_clk);
      train_start = 1'b1;
      @(negedge fab_clk);
      train_start = 1'b0;
    end
    cyc = 0;
    while (!(train_done || train_err) && cyc < 6000) begin
      @(negedge fab_clk);
      cyc++;
    end
    chk({tag, "_finished"}, int'(train_done || train_err), 1);
    #2;
    chk({tag, "_done"}, int'(train_done), int'(!exp_err));
    chk({tag, "_err"}, int'(train_err), int'(exp_err));
    chk({tag, "_tap"}, int'(tap_count), exp_tap);
    chk({tag, "_moves"}, n_move - m0, exp_tap);
    chk({tag, "_moves_down"}, n_move_dn - md0, 0);
    chk({tag, "_loads"}, n_load - l0, 1);
    chk({tag, "_dqs_cycles"}, n_pulse - p0, probes * BURST_LEN + er * SETTLE_CYCLES);
    chk({tag, "_wide_strobes"}, n_wide - w0, 0);
    chk({tag, "_bad_pattern"}, n_badpat - b0, 0);
    chk({tag, "_eye_clears"}, n_clr - c0, er);
    chk({tag, "_odt_off"}, int'(odt_en_0), 0);
    repeat (5) @(negedge fab_clk);
    chk({tag, "_tap_hold"}, int'(tap_count), exp_tap);
  endtask

  initial begin
    int lk, p0;
    arst_n = 1'b0;
    train_start = 1'b0;
    oor_en = 1'b0;
    oor_tap = 8'd0;
    eye_early = 1'b0;
    eye_late = 1'b0;
    fill(0);
    #12;
    chk("reset_outputs", int'(out_vec), 0);
    @(negedge fab_clk);
    arst_n = 1'b1;
    repeat (3) @(negedge fab_clk);
    chk("idle_after_reset", int'(out_vec), 0);

    fill(1);
    sweep("edge_at_40", 42, 1'b0, 43, EYE_R, 1'b0);
    fill(2);
    sweep("leading_ones", 32, 1'b0, 33, EYE_R, 1'b0);
    fill(3);
    sweep("glitch_at_20", 27, 1'b0, 28, EYE_R, 1'b0);
    fill(0);
    sweep("never_locks", 127, 1'b1, 128, EYE_R, 1'b0);

    oor_en = 1'b1;
    oor_tap = 8'd15;
    sweep("out_of_range", 15, 1'b1, 15, EYE_R, 1'b0);
    oor_en = 1'b0;
    fill(1);
    sweep("restart_after_err", 42, 1'b0, 43, EYE_R, 1'b1);

    for (int i = 0; i < 5; i++) begin
      fill(4);
      lk = ref_lock();
      if (lk < 0) sweep("random", 127, 1'b1, 128, EYE_R, i[0]);
      else        sweep("random", lk, 1'b0, lk + 1, EYE_R, i[0]);
    end

    // Reset arrives asynchronously in the middle of a sweep.
    fill(5);
    @(negedge fab_clk);
    train_start = 1'b1;
    @(negedge fab_clk);
    train_start = 1'b0;
    repeat (300) @(negedge fab_clk);
    #3;
    arst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(out_vec), 0);
    @(negedge fab_clk);
    arst_n = 1'b1;
    #2;
    p0 = n_pulse;
    repeat (10) @(negedge fab_clk);
    #2;
    chk("post_reset_quiet", n_pulse - p0, 0);
    chk("post_reset_idle", int'(out_vec), 0);
    fill(1);
    sweep("after_async_reset", 42, 1'b0, 43, EYE_R, 1'b0);

`ifdef DQSW_EYE_CHECK_EN
    eye_early = 1'b1;
    sweep("eye_early_twice", 44, 1'b0, 43, 2, 1'b0);
    eye_early = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
